controlador_turnos: RTL

Game sequencer for the tic-tac-toe datapath. It accepts move requests from the player input logic, validates them against the current board, and drives the board's placement handshake (`pos`, `jugador`, `colocar` / `colocado`). It alternates turns, reads the registered win detector after each placement and declares a winner or a draw. It sits between the input/debounce logic and the `Matriz` board, with `Ganador` feeding back `win`.

---
 rtl/controlador_turnos.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/controlador_turnos.sv
// controlador_turnos: tic-tac-toe game sequencer.
// Validates move requests against the board and drives the placement
// handshake (pos/jugador/colocar, acked by colocado). After each placement
// it reads the registered win flag, then declares a win or a draw, or passes
// the turn to the other player.
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after the player
// has idled TURN_TIMEOUT cycles in ESPERA. Without it, timeout is tied to 0.
module controlador_turnos #(
    parameter int TURN_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mov_valido,
    input  logic [3:0]      mov_pos,
    input  logic [8:0][1:0] matriz,
    input  logic            colocado,
    input  logic            win,
    input  logic            nuevo_juego,
    output logic [3:0]      pos,
    output logic            jugador,
    output logic            colocar,
    output logic            rechazo,
    output logic            timeout,
    output logic            limpiar,
    output logic            fin,
    output logic            empate,
    output logic            ganador
);

    typedef enum logic [2:0] {
        ESPERA,
        COLOCA,
        VERIFICA,
        FIN,
        LIMPIA
    } estado_t;

    estado_t    estado, estado_n;
    logic [3:0] cuenta, cuenta_n;   // placed moves, 0..9
    logic       fase, fase_n;       // 0 = first VERIFICA cycle, 1 = second
    logic [3:0] pos_n;
    logic       jugador_n, colocar_n, rechazo_n, limpiar_n;
    logic       fin_n, empate_n, ganador_n;
    logic       ocupada;            // requested cell is off-board or taken

`ifdef TURN_TIMEOUT_EN
    localparam int TW = (TURN_TIMEOUT < 2) ? 1 : $clog2(TURN_TIMEOUT);
    logic [TW-1:0] timer, timer_n;
    logic          timeout_n;
`else
    assign timeout = 1'b0;
`endif

    // Cell lookup; indices above 8 are treated as occupied so they get rejected.
    always_comb begin
        ocupada = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (mov_pos == 4'(i))
                ocupada = |matriz[i];
        end
    end

    // State register plus every registered output, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado  <= ESPERA;
            cuenta  <= 4'd0;
            fase    <= 1'b0;
            pos     <= 4'd0;
            jugador <= 1'b0;
            colocar <= 1'b0;
            rechazo <= 1'b0;
            limpiar <= 1'b0;
            fin     <= 1'b0;
            empate  <= 1'b0;
            ganador <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            timer   <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            estado  <= estado_n;
            cuenta  <= cuenta_n;
            fase    <= fase_n;
            pos     <= pos_n;
            jugador <= jugador_n;
            colocar <= colocar_n;
            rechazo <= rechazo_n;
            limpiar <= limpiar_n;
            fin     <= fin_n;
            empate  <= empate_n;
            ganador <= ganador_n;
`ifdef TURN_TIMEOUT_EN
            timer   <= timer_n;
            timeout <= timeout_n;
`endif
        end
    end

    // Next-state and next-output logic; pulses default low, held outputs keep value.
    always_comb begin
        estado_n  = estado;
        cuenta_n  = cuenta;
        fase_n    = 1'b0;
        pos_n     = pos;
        jugador_n = jugador;
        colocar_n = colocar;
        rechazo_n = 1'b0;
        limpiar_n = 1'b0;
        fin_n     = fin;
        empate_n  = empate;
        ganador_n = ganador;
`ifdef TURN_TIMEOUT_EN
        timer_n   = timer;
        timeout_n = 1'b0;
`endif
        case (estado)
            ESPERA: begin
`ifdef TURN_TIMEOUT_EN
                timer_n = timer + 1'b1;
`endif
                if (mov_valido && !ocupada) begin
                    // An accepted move beats a timer expiring in the same cycle.
                    pos_n     = mov_pos;
                    colocar_n = 1'b1;
                    estado_n  = COLOCA;
`ifdef TURN_TIMEOUT_EN
                    timer_n   = '0;
`endif
                end else begin
                    if (mov_valido)
                        rechazo_n = 1'b1;
`ifdef TURN_TIMEOUT_EN
                    // Rejected moves do not restart the timer.
                    if (timer == TW'(TURN_TIMEOUT - 1)) begin
                        timeout_n = 1'b1;
                        jugador_n = ~jugador;
                        timer_n   = '0;
                    end
`endif
                end
            end
            COLOCA: begin
                if (colocado) begin
                    colocar_n = 1'b0;
                    cuenta_n  = cuenta + 4'd1;
                    estado_n  = VERIFICA;
                end
            end
            VERIFICA: begin
                // The first cycle lets the registered win flag catch up with the board.
                if (!fase) begin
                    fase_n = 1'b1;
                end else if (win) begin
                    fin_n     = 1'b1;
                    ganador_n = jugador;
                    estado_n  = FIN;
                end else if (cuenta == 4'd9) begin
                    fin_n    = 1'b1;
                    empate_n = 1'b1;
                    estado_n = FIN;
                end else begin
                    jugador_n = ~jugador;
                    estado_n  = ESPERA;
`ifdef TURN_TIMEOUT_EN
                    timer_n   = '0;
`endif
                end
            end
            FIN: begin
                if (nuevo_juego) begin
                    limpiar_n = 1'b1;
                    estado_n  = LIMPIA;
                end
            end
            LIMPIA: begin
                fin_n     = 1'b0;
                empate_n  = 1'b0;
                ganador_n = 1'b0;
                jugador_n = 1'b0;
                pos_n     = 4'd0;
                cuenta_n  = 4'd0;
                estado_n  = ESPERA;
`ifdef TURN_TIMEOUT_EN
                timer_n   = '0;
`endif
            end
            default: estado_n = ESPERA;
        endcase
    end

endmodule
